alu_sequencer: RTL and testbench

Multi-cycle control sequencer that drives the `alu` block. It accepts 16-bit instruction words over a valid/ready handshake and owns the A and D registers and the program counter. It decodes each word into the ALU control lines (zero_x, zero_y, negate_output, opcode), consumes the ALU result and flags, and performs register/memory writeback and conditional jumps. It sits between instruction fetch and the ALU/data-memory pair.

---
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller that owns A, D and pc and drives the alu.
// Loads commit in one cycle; computes run IDLE -> EXEC -> WB -> IDLE.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        zero_x,
  output logic        zero_y,
  output logic        negate_output,
  output logic [1:0]  opcode,
  input  logic [15:0] output_result,
  input  logic        is_zero,
  input  logic        is_negative,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] pc,
  output logic        retire
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       zx;
    logic       zy;
    logic       neg;
    logic       ysel;
    logic       da;
    logic       dd;
    logic       dm;
    logic       jlt;
    logic       jeq;
    logic       jgt;
  } ctl_t;

  state_t      state_q, state_d;
  ctl_t        ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] pc_q, pc_d;
  logic        retire_q, retire_d;
  logic        taken;
  logic        unused_bits;

  assign unused_bits = &{1'b0, instr[5:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      a_q      <= '0;
      d_q      <= '0;
      pc_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      d_q      <= d_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
    end
  end

  assign taken = (ir_q.jlt & is_negative)
               | (ir_q.jeq & is_zero)
               | (ir_q.jgt & ~is_zero & ~is_negative);

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    a_d           = a_q;
    d_d           = d_q;
    pc_d          = pc_q;
    retire_d      = 1'b0;
    instr_ready   = 1'b0;
    zero_x        = 1'b0;
    zero_y        = 1'b0;
    negate_output = 1'b0;
    opcode        = 2'b00;
    y             = a_q;
    mem_we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (!instr[15]) begin
            a_d      = {1'b0, instr[14:0]};
            pc_d     = pc_q + 16'd1;
            retire_d = 1'b1;
          end else begin
            ir_d    = {instr[14:6], instr[2:0]};
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        zero_x        = ir_q.zx;
        zero_y        = ir_q.zy;
        negate_output = ir_q.neg;
        opcode        = ir_q.op;
        y             = ir_q.ysel ? mem_rdata : a_q;
        state_d       = WB;
      end
      WB: begin
        zero_x        = ir_q.zx;
        zero_y        = ir_q.zy;
        negate_output = ir_q.neg;
        opcode        = ir_q.op;
        y             = ir_q.ysel ? mem_rdata : a_q;
        mem_we        = ir_q.dm;
        if (ir_q.da) a_d = output_result;
        if (ir_q.dd) d_d = output_result;
        // jump target is the A value held before this instruction's writeback
        pc_d     = taken ? a_q : pc_q + 16'd1;
        retire_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign x         = d_q;
  assign mem_addr  = a_q;
  assign mem_wdata = output_result;
  assign pc        = pc_q;
  assign retire    = retire_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a registered alu
// model and a small combinational data memory.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [15:0] x, y;
  logic        zero_x, zero_y, negate_output;
  logic [1:0]  opcode;
  logic [15:0] output_result = '0;
  logic        is_zero = 1'b0;
  logic        is_negative = 1'b0;
  logic [15:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_we;
  logic [15:0] pc;
  logic        retire;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:255];
  logic [15:0] xx, yy, rr;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .x(x), .y(y),
    .zero_x(zero_x), .zero_y(zero_y), .negate_output(negate_output),
    .opcode(opcode),
    .output_result(output_result),
    .is_zero(is_zero), .is_negative(is_negative),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .pc(pc), .retire(retire)
  );

  // alu model: 0 and, 1 or, 2 add, 3 xor; negate is bitwise invert
  always_comb begin
    xx = zero_x ? 16'h0 : x;
    yy = zero_y ? 16'h0 : y;
    case (opcode)
      2'd0: rr = xx & yy;
      2'd1: rr = xx | yy;
      2'd2: rr = xx + yy;
      default: rr = xx ^ yy;
    endcase
    if (negate_output) rr = ~rr;
  end

  always @(posedge clk) begin
    output_result <= rr;
    is_zero       <= (rr == 16'h0);
    is_negative   <= rr[15];
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL send_timeout: instr_ready=%b required 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr = w;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (pc !== 16'h0) begin
      fails++; $display("FAIL reset_pc: got %h required 0000", pc);
    end
    tests++;
    if (mem_addr !== 16'h0 || x !== 16'h0) begin
      fails++; $display("FAIL reset_ad: A=%h D=%h required 0", mem_addr, x);
    end
    tests++;
    if (instr_ready !== 1'b1 || retire !== 1'b0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: rdy=%b ret=%b we=%b required 1 0 0",
               instr_ready, retire, mem_we);
    end
  endtask

  task automatic test_load_compute();
    send(16'h0005);
    tests++;
    if (retire !== 1'b1 || pc !== 16'h1 || mem_addr !== 16'h5) begin
      fails++;
      $display("FAIL load: ret=%b pc=%h A=%h required 1 0001 0005",
               retire, pc, mem_addr);
    end
    send(16'hD080);
    tests++;
    if (instr_ready !== 1'b0 || opcode !== 2'd2 || zero_x !== 1'b1
        || y !== 16'h5 || retire !== 1'b0) begin
      fails++;
      $display("FAIL exec: rdy=%b op=%h zx=%b y=%h ret=%b required 0 2 1 0005 0",
               instr_ready, opcode, zero_x, y, retire);
    end
    @(negedge clk);
    tests++;
    if (instr_ready !== 1'b0 || retire !== 1'b0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL wb: rdy=%b ret=%b we=%b required 0 0 0",
               instr_ready, retire, mem_we);
    end
    @(negedge clk);
    tests++;
    if (retire !== 1'b1 || pc !== 16'h2 || x !== 16'h5 || instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL commit: ret=%b pc=%h D=%h rdy=%b required 1 0002 0005 1",
               retire, pc, x, instr_ready);
    end
  endtask

  task automatic test_mem_write();
    send(16'h0002);
    send(16'hD080);
    repeat (2) @(negedge clk);
    send(16'h0010);
    send(16'hC040);
    tests++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL memw_exec: we=%b required 0", mem_we);
    end
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h0012) begin
      fails++;
      $display("FAIL memw_wb: we=%b addr=%h data=%h required 1 0010 0012",
               mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b0 || mem[8'h10] !== 16'h0012) begin
      fails++;
      $display("FAIL memw_after: we=%b mem=%h required 0 0012",
               mem_we, mem[8'h10]);
    end
  endtask

  task automatic test_jump();
    send(16'h0040);
    send(16'hD802);
    repeat (2) @(negedge clk);
    tests++;
    if (pc !== 16'h0040) begin
      fails++; $display("FAIL jeq_taken: pc=%h required 0040", pc);
    end
    send(16'hD804);
    repeat (2) @(negedge clk);
    tests++;
    if (pc !== 16'h0041) begin
      fails++; $display("FAIL jlt_not: pc=%h required 0041", pc);
    end
  endtask

  task automatic test_jump_codes();
    logic [15:0] base [3];
    logic [7:0]  mask [3];
    logic [15:0] exp_pc, w;
    base[0] = 16'hD800; mask[0] = 8'b1100_1100;
    base[1] = 16'hDC00; mask[1] = 8'b1111_0000;
    base[2] = 16'hD000; mask[2] = 8'b1010_1010;
    do_reset();
    exp_pc = 16'h0;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 8; j++) begin
        send(16'h0040);
        exp_pc = exp_pc + 16'd1;
        w = base[s] | 16'(j);
        send(w);
        repeat (2) @(negedge clk);
        exp_pc = mask[s][j] ? 16'h0040 : exp_pc + 16'd1;
        tests++;
        if (pc !== exp_pc) begin
          fails++;
          $display("FAIL jcode s%0d j%0d: pc=%h required %h", s, j, pc, exp_pc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    send(16'hDD00);
    repeat (2) @(negedge clk);
    tests++;
    if (mem_addr !== 16'hFFFF) begin
      fails++; $display("FAIL setA: A=%h required ffff", mem_addr);
    end
    send(16'hD902);
    repeat (2) @(negedge clk);
    tests++;
    if (pc !== 16'hFFFF || mem_addr !== 16'h0) begin
      fails++;
      $display("FAIL jump_destA: pc=%h A=%h required ffff 0000", pc, mem_addr);
    end
    send(16'h0001);
    tests++;
    if (pc !== 16'h0000 || mem_addr !== 16'h1) begin
      fails++;
      $display("FAIL wrap: pc=%h A=%h required 0000 0001", pc, mem_addr);
    end
  endtask

  task automatic test_reset_mid_wb();
    send(16'h0007);
    send(16'hD0C0);
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1) begin
      fails++; $display("FAIL rst_pre: we=%b required 1", mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (mem_we !== 1'b0 || mem_addr !== 16'h0 || x !== 16'h0
        || pc !== 16'h0 || instr_ready !== 1'b1 || retire !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: we=%b A=%h D=%h pc=%h rdy=%b ret=%b required 0 0 0 0 1 0",
               mem_we, mem_addr, x, pc, instr_ready, retire);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (retire !== 1'b0 || x !== 16'h0 || pc !== 16'h0) begin
        fails++;
        $display("FAIL rst_after: ret=%b D=%h pc=%h required 0 0 0",
                 retire, x, pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [6];
    int idx, rets, lows, cyc;
    logic rdy;
    words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
    words[3] = 16'hD080; words[4] = 16'h0004; words[5] = 16'h0005;
    do_reset();
    idx = 0; rets = 0; lows = 0; cyc = 0;
    while (idx < 6 && cyc < 40) begin
      @(negedge clk);
      if (retire) rets++;
      if (!instr_ready) lows++;
      instr_valid = 1'b1;
      instr = words[idx];
      rdy = instr_ready;
      @(posedge clk);
      if (rdy) idx++;
      cyc++;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    if (retire) rets++;
    tests++;
    if (idx != 6 || cyc != 8) begin
      fails++; $display("FAIL b2b_accepts: idx=%0d cyc=%0d required 6 8", idx, cyc);
    end
    tests++;
    if (rets != 6 || lows != 2) begin
      fails++; $display("FAIL b2b_counts: ret=%0d low=%0d required 6 2", rets, lows);
    end
    tests++;
    if (pc !== 16'h6 || x !== 16'h3 || mem_addr !== 16'h5) begin
      fails++;
      $display("FAIL b2b_state: pc=%h D=%h A=%h required 0006 0003 0005",
               pc, x, mem_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_load_compute();
    test_mem_write();
    test_jump();
    test_jump_codes();
    test_wrap();
    test_reset_mid_wb();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
